// File: rtl/ripple_compare.sv
// Registered magnitude comparator built on an explicit ripple-borrow subtractor chain.
// Define RIPPLE_SIGNED_EN to make out_q1 a two's-complement signed less-than.

module ripple_fsub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

module ripple_compare #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_q1,
    output logic             out_q2
);

    logic [WIDTH:0]   bor;
    logic [WIDTH-1:0] diff;
    logic             lt_comb;
    logic             eq_comb;

    assign bor[0] = 1'b0;

    // Borrow ripples strictly LSB to MSB through one cell per bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        ripple_fsub_cell u_cell (
            .a    (in_a[i]),
            .b    (in_b[i]),
            .bin  (bor[i]),
            .diff (diff[i]),
            .bout (bor[i+1])
        );
    end

`ifdef RIPPLE_SIGNED_EN
    // Differing sign bits decide directly; otherwise the unsigned borrow is correct.
    assign lt_comb = (in_a[WIDTH-1] ^ in_b[WIDTH-1]) ? in_a[WIDTH-1] : bor[WIDTH];
`else
    assign lt_comb = bor[WIDTH];
`endif

    assign eq_comb = ~|diff;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q1 <= 1'b0;
            out_q2 <= 1'b0;
        end else begin
            out_q1 <= lt_comb;
            out_q2 <= eq_comb;
        end
    end

endmodule

// File: tb/tb_ripple_compare.sv
// Directed and random self-checking bench for ripple_compare; follows RIPPLE_SIGNED_EN.

module tb_ripple_compare;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_q1;
    logic             out_q2;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    ripple_compare #(.WIDTH(WIDTH)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .in_a   (in_a),
        .in_b   (in_b),
        .out_q1 (out_q1),
        .out_q2 (out_q2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic model_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef RIPPLE_SIGNED_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
    endfunction

    task automatic apply_check(input string tag, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic exp_lt,
                               input logic exp_eq);
        in_a = a;
        in_b = b;
        tick();
        check({tag, "_q1"}, 32'(out_q1), 32'(exp_lt));
        check({tag, "_q2"}, 32'(out_q2), 32'(exp_eq));
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             signed_lt;

`ifdef RIPPLE_SIGNED_EN
        signed_lt = 1'b1;
`else
        signed_lt = 1'b0;
`endif

        reset = 1'b1;
        in_a  = 32'd5;
        in_b  = 32'd9;
        tick();
        check("rst0_q1", 32'(out_q1), 32'd0);
        check("rst0_q2", 32'(out_q2), 32'd0);
        tick();
        check("rst1_q1", 32'(out_q1), 32'd0);
        check("rst1_q2", 32'(out_q2), 32'd0);
        reset = 1'b0;
        apply_check("post_rst", 32'd5, 32'd9, 1'b1, 1'b0);

        apply_check("ffff_f7da", 32'h0000FFFF, 32'h0000F7DA, 1'b0, 1'b0);
        apply_check("one_three", 32'd1, 32'd3, 1'b1, 1'b0);
        apply_check("three_three", 32'd3, 32'd3, 1'b0, 1'b1);
        apply_check("zero_zero", 32'd0, 32'd0, 1'b0, 1'b1);
        // 0 vs all-ones: signed reads as 0 < -1 false
        apply_check("zero_ones", 32'h0, 32'hFFFFFFFF, ~signed_lt, 1'b0);
        apply_check("ones_zero", 32'hFFFFFFFF, 32'h0, signed_lt, 1'b0);
        apply_check("msb_vs_max", 32'h80000000, 32'h7FFFFFFF, signed_lt, 1'b0);
        apply_check("ones_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
        apply_check("lsb_only", 32'h00000000, 32'h00000001, 1'b1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom();
            rb = (i % 8 == 0) ? ra : 32'($urandom());
            in_a = ra;
            in_b = rb;
            tick();
            check("rnd_q1", 32'(out_q1), 32'(model_lt(ra, rb)));
            check("rnd_q2", 32'(out_q2), 32'(ra == rb));
            check("rnd_excl", 32'(out_q1 & out_q2), 32'd0);
        end

        in_a  = 32'd2;
        in_b  = 32'd7;
        reset = 1'b1;
        tick();
        check("mid_rst_q1", 32'(out_q1), 32'd0);
        check("mid_rst_q2", 32'(out_q2), 32'd0);
        reset = 1'b0;
        apply_check("mid_resume", 32'd2, 32'd7, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ripple_compare.md
Name: ripple_compare

Overview:
- Registered 32-bit magnitude comparator built on an explicit ripple-borrow subtractor chain: one full-subtractor cell per bit, borrow propagating from LSB to MSB.
- Compares in_a against in_b every clock.
- Outputs two registered flags: "a less than b" and "a equal to b".
- Used as a small datapath building block and as a ripple-chain timing/structure reference.

Parameters:
- WIDTH, 32, operand width in bits; must be >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_a  input  WIDTH  operand A, sampled every rising edge.
- in_b  input  WIDTH  operand B, sampled every rising edge.
- out_q1  output  1  registered less-than flag: 1 when A < B.
- out_q2  output  1  registered equality flag: 1 when A == B.

Behaviour:
- Interface clocking (already decided): one clock; reset is synchronous and active-high.
- Ripple chain:
  - Per bit i: diff[i] = a[i] ^ b[i] ^ bor[i].
  - bor[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bor[i]).
  - bor[0] = 0.
  - Implemented as WIDTH instances of a one-bit full-subtractor cell in a generate loop.
  - No carry-lookahead; synthesis-level replacement by a '<' operator is not permitted.
- Compare results (combinational):
  - Unsigned less-than = bor[WIDTH], the final borrow.
  - Equality = NOR-reduction of diff[WIDTH-1:0].
- Registers:
  - out_q1 and out_q2 are flops loaded every rising clk edge from the combinational results.
  - Latency is exactly 1 cycle from operands to flags; throughput is one compare per cycle.
  - No enable or handshake.
- Reset:
  - While reset=1 at a rising edge, out_q1 <= 0 and out_q2 <= 0, regardless of operands.
  - The first compare result appears on the edge after reset deasserts.
  - Reset asserted mid-stream discards the in-flight result.
- Invariant: out_q1 and out_q2 are never both 1.
- Boundaries:
  - A=B=0 gives q1=0, q2=1.
  - A=0, B=all-ones gives q1=1, q2=0.
  - A=all-ones, B=0 gives q1=0, q2=0.
  - Any X/Z on inputs is not supported; behaviour is unspecified.
- No internal state besides the two output flops.

Optional Feature:
- Macro: RIPPLE_SIGNED_EN.
- When defined, out_q1 is the two's-complement signed less-than.
  - Computed as lt = (a[MSB] ^ b[MSB]) ? a[MSB] : bor[WIDTH], still derived from the same ripple chain.
  - Equality is unchanged.
- When not defined, out_q1 is the unsigned less-than (default).
- Latency, reset and port list are identical in both builds.

Test Plan:
- Hold reset=1 for 2 cycles with in_a=5, in_b=9 -> out_q1=0, out_q2=0 throughout; one cycle after release -> out_q1=1, out_q2=0.
- in_a=32'h0000FFFF, in_b=32'h0000F7DA -> after 1 cycle out_q1=0, out_q2=0.
- in_a=1, in_b=3 -> after 1 cycle out_q1=1, out_q2=0; then in_a=3, in_b=3 -> out_q1=0, out_q2=1.
- Full borrow ripple:
  - in_a=0, in_b=32'hFFFFFFFF -> out_q1=1, out_q2=0.
  - in_a=32'h80000000, in_b=32'h7FFFFFFF -> unsigned build out_q1=0; RIPPLE_SIGNED_EN build out_q1=1.
- Back-to-back: change operands every cycle across 1000 random pairs -> each cycle's flags match the golden compare of the previous cycle's operands, and q1&q2 is never 1.
- Assert reset for one cycle mid-stream with in_a=2, in_b=7 -> flags 0 on that edge, valid compare resumes the next edge.
